array_to_mem: RTL and testbench

ARRAY_TO_MEM -- requirements
Module: array_to_mem

---
 rtl/array_to_mem.sv | 159 +++++++++++++++
 tb/tb_array_to_mem.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_to_mem.sv
// array_to_mem: captures one 8x8 block of 32-bit words and streams it to a
// word-addressed memory, one word per cycle, starting at
//   base = offset + (counter % MAX_BLOCK_NUM) * MAX_PIXEL_NUM  (mod 2^ADDR_WIDTH).
//
// Ports
//   clock             rising-edge clock for all state
//   reset_n           asynchronous active-low reset
//   in_valid          block/counter/offset valid
//   in_ready          block can be accepted this cycle (registered)
//   input_data_array  block to store, [row][col], 32-bit words
//   counter           block counter, sampled at accept
//   offset            base word address, sampled at accept
//   mem_we            memory write enable
//   mem_addr          memory word address
//   mem_wdata         memory write data
//   busy              high while the block is being written
//   done              one-cycle pulse after the last word
module array_to_mem #(
    parameter int unsigned MAX_BLOCK_NUM = 32,
    parameter int unsigned MAX_PIXEL_NUM = 64,
    parameter int unsigned ADDR_WIDTH    = 12
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0][7:0][31:0]       input_data_array,
    input  logic [31:0]                 counter,
    input  logic [31:0]                 offset,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [31:0]                 mem_wdata,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_WORDS = 64;
    localparam int unsigned IDX_W     = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [IDX_W-1:0]            idx_nxt;
    logic [7:0][7:0][DATA_W-1:0] buf_q;
    logic                        load;

    logic                        in_ready_d;
    logic                        mem_we_d;
    logic [ADDR_WIDTH-1:0]       mem_addr_d;
    logic [DATA_W-1:0]           mem_wdata_d;
    logic                        busy_d;
    logic                        done_d;

    logic                        accept;
    logic [31:0]                 blk_sel;
    logic [ADDR_WIDTH-1:0]       base;

    // Handshake: in_ready is only ever high in IDLE, the state check is belt and braces.
    assign accept = in_valid && in_ready && (state_q == IDLE);

    // Start address of the block in memory; truncation gives the modulo wrap.
    always_comb begin
        blk_sel = counter % MAX_BLOCK_NUM;
        base    = ADDR_WIDTH'(offset + blk_sel * 32'(MAX_PIXEL_NUM));
    end

    assign idx_nxt = idx_q + IDX_W'(1);

    // Next-state and next-output logic; every output is registered below,
    // so the values computed here appear one cycle later.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        load        = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // Word 0 comes straight from the inputs so the first
                    // write lands in the cycle right after the accept edge.
                    load        = 1'b1;
                    state_d     = WRITE;
                    idx_d       = '0;
                    mem_we_d    = 1'b1;
                    busy_d      = 1'b1;
                    mem_addr_d  = base;
                    mem_wdata_d = input_data_array[0][0];
                end
            end

            WRITE: begin
                if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
                    state_d = DONE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d       = idx_nxt;
                    mem_we_d    = 1'b1;
                    busy_d      = 1'b1;
                    mem_addr_d  = mem_addr + ADDR_WIDTH'(1);
                    mem_wdata_d = buf_q[idx_nxt[5:3]][idx_nxt[2:0]];
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            in_ready  <= in_ready_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Block buffer; contents after reset are irrelevant, so no reset term.
    always_ff @(posedge clock) begin
        if (load) begin
            buf_q <= input_data_array;
        end
    end

endmodule

// File: tb/tb_array_to_mem.sv
module tb_array_to_mem;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [7:0][7:0][31:0]  din = '0;
    logic [31:0]            cnt_in = '0;
    logic [31:0]            off_in = '0;
    logic                   mem_we;
    logic [11:0]            mem_addr;
    logic [31:0]            mem_wdata;
    logic                   busy;
    logic                   done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    array_to_mem #(
        .MAX_BLOCK_NUM(32),
        .MAX_PIXEL_NUM(64),
        .ADDR_WIDTH(12)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .input_data_array(din),
        .counter(cnt_in),
        .offset(off_in),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .busy(busy),
        .done(done)
    );

    always #5 clock = ~clock;

    // Expected outputs for one cycle; chk says whether addr/data are defined.
    typedef struct packed {
        logic        rdy;
        logic        we;
        logic        busy;
        logic        done;
        logic        chk;
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t cur = '{rdy: 1'b0, we: 1'b0, busy: 1'b0, done: 1'b0, chk: 1'b1, addr: '0, data: '0};
    exp_t q[$];
    int   acc_cyc[$];
    int   done_cyc[$];
    logic [11:0] log_addr[$];
    logic [31:0] log_data[$];

    function automatic logic [7:0][7:0][31:0] pat(input logic [31:0] seed);
        logic [7:0][7:0][31:0] r;
        for (int j = 0; j < 8; j++)
            for (int k = 0; k < 8; k++)
                r[j][k] = seed + 32'(j * 8 + k);
        return r;
    endfunction

    // Timeline model: an accepted block schedules 64 write cycles and a done cycle;
    // with nothing scheduled the block sits idle and ready.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            cur = '{rdy: 1'b0, we: 1'b0, busy: 1'b0, done: 1'b0, chk: 1'b1, addr: '0, data: '0};
        end else begin
            exp_t e;
            logic [31:0] b;
            cyc++;
            if (cur.rdy && in_valid) begin
                acc_cyc.push_back(cyc);
                b = off_in + (cnt_in % 32) * 64;
                for (int n = 0; n < 64; n++) begin
                    e = '{rdy: 1'b0, we: 1'b1, busy: 1'b1, done: 1'b0, chk: 1'b1,
                          addr: 12'(b + 32'(n)), data: din[n / 8][n % 8]};
                    q.push_back(e);
                end
                e = '{rdy: 1'b0, we: 1'b0, busy: 1'b0, done: 1'b1, chk: 1'b0, addr: '0, data: '0};
                q.push_back(e);
            end
            if (q.size() > 0)
                cur = q.pop_front();
            else
                cur = '{rdy: 1'b1, we: 1'b0, busy: 1'b0, done: 1'b0, chk: 1'b0, addr: '0, data: '0};
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        tests++;
        if ({in_ready, mem_we, busy, done} !== {cur.rdy, cur.we, cur.busy, cur.done} ||
            (cur.chk && (mem_addr !== cur.addr || mem_wdata !== cur.data))) begin
            fails++;
            $display("FAIL cycle_cmp @%0d: rdy/we/busy/done=%b%b%b%b addr=%h data=%h, required %b%b%b%b addr=%h data=%h",
                     cyc, in_ready, mem_we, busy, done, mem_addr, mem_wdata,
                     cur.rdy, cur.we, cur.busy, cur.done, cur.addr, cur.data);
        end
    end

    // Write and done log for the literal checks.
    always @(negedge clock) begin
        if (reset_n && mem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
        if (reset_n && done)
            done_cyc.push_back(cyc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_data.delete();
        acc_cyc.delete();
        done_cyc.delete();
    endtask

    // Present a block and hold in_valid until it has been taken.
    task automatic send_block(input logic [31:0] c, input logic [31:0] o, input logic [31:0] seed);
        int t = 0;
        din      = pat(seed);
        cnt_in   = c;
        off_in   = o;
        in_valid = 1'b1;
        while (!in_ready && t < 300) begin
            step();
            t++;
        end
        if (t >= 300) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0, required 1 within 300 cycles");
        end else begin
            step();
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(q.size() == 0 && cur.rdy) && t < 300) begin
            step();
            t++;
        end
        if (t >= 300) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got busy model, required idle within 300 cycles");
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset_n = 1'b0;
        step();
        step();
        chk("reset_outputs", 32'({in_ready, mem_we, busy, done, mem_addr, mem_wdata}), 32'd0);
        #1 reset_n = 1'b1;
        #1 chk("ready_low_before_edge", 32'(in_ready), 32'd0);
        step();
        chk("ready_after_first_edge", 32'(in_ready), 32'd1);

        // Basic block.
        clear_logs();
        send_block(0, 0, 1);
        in_valid = 1'b0;
        wait_idle();
        chk("basic_count", 32'(log_addr.size()), 32'd64);
        if (log_addr.size() == 64) begin
            chk("basic_addr0", 32'(log_addr[0]), 32'h0);
            chk("basic_data0", log_data[0], 32'd1);
            chk("basic_addr63", 32'(log_addr[63]), 32'd63);
            chk("basic_data63", log_data[63], 32'd64);
        end
        chk("basic_done_count", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() == 1 && acc_cyc.size() == 1)
            chk("basic_done_latency", 32'(done_cyc[0] - acc_cyc[0]), 32'd64);

        // Block index wrap.
        clear_logs();
        send_block(33, 32'h100, 32'h10);
        in_valid = 1'b0;
        wait_idle();
        chk("bwrap_count", 32'(log_addr.size()), 32'd64);
        if (log_addr.size() == 64) begin
            chk("bwrap_addr0", 32'(log_addr[0]), 32'h140);
            chk("bwrap_addr63", 32'(log_addr[63]), 32'h17F);
            chk("bwrap_data0", log_data[0], 32'h10);
        end

        // Address wrap.
        clear_logs();
        send_block(0, 32'hFE0, 32'h20);
        in_valid = 1'b0;
        wait_idle();
        chk("awrap_count", 32'(log_addr.size()), 32'd64);
        if (log_addr.size() == 64) begin
            chk("awrap_addr31", 32'(log_addr[31]), 32'hFFF);
            chk("awrap_addr32", 32'(log_addr[32]), 32'h000);
            chk("awrap_addr63", 32'(log_addr[63]), 32'h01F);
            chk("awrap_data32", log_data[32], 32'h40);
        end

        // Hold-off: in_valid stays high while inputs keep changing.
        clear_logs();
        send_block(5, 32'h40, 32'hA000);
        for (int i = 0; i < 70; i++) begin
            step();
            din    = pat(32'hB000 + 32'(i) * 32'h100);
            cnt_in = 32'(i);
        end
        in_valid = 1'b0;
        wait_idle();
        chk("hold_accepts", 32'(acc_cyc.size()), 32'd2);
        if (acc_cyc.size() == 2)
            chk("hold_accept_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd66);
        chk("hold_count", 32'(log_addr.size()), 32'd128);
        if (log_addr.size() == 128) begin
            chk("hold_addr0", 32'(log_addr[0]), 32'h180);
            chk("hold_data0", log_data[0], 32'hA000);
            chk("hold_data63", log_data[63], 32'hA03F);
            chk("hold_addr64", 32'(log_addr[64]), 32'h040);
            chk("hold_data64", log_data[64], 32'hF000);
        end

        // Mid-block reset after 20 writes.
        clear_logs();
        send_block(2, 32'h200, 32'hC000);
        in_valid = 1'b0;
        begin
            int t = 0;
            while (log_addr.size() < 20 && t < 100) begin
                step();
                t++;
            end
        end
        chk("mid_reached_20", 32'(log_addr.size()), 32'd20);
        #1 reset_n = 1'b0;
        #1 chk("mid_we_async", 32'({mem_we, busy}), 32'd0);
        step();
        step();
        #1 reset_n = 1'b1;
        step();
        chk("mid_ready_after", 32'(in_ready), 32'd1);
        chk("mid_writes_stop", 32'(log_addr.size()), 32'd20);
        chk("mid_no_done", 32'(done_cyc.size()), 32'd0);
        clear_logs();
        send_block(3, 32'h200, 32'hD000);
        in_valid = 1'b0;
        wait_idle();
        chk("fresh_count", 32'(log_addr.size()), 32'd64);
        if (log_addr.size() == 64) begin
            chk("fresh_addr0", 32'(log_addr[0]), 32'h2C0);
            chk("fresh_data63", log_data[63], 32'hD03F);
        end
        chk("fresh_done", 32'(done_cyc.size()), 32'd1);

        // Back-to-back blocks.
        clear_logs();
        send_block(0, 0, 32'h1000);
        send_block(1, 0, 32'h2000);
        send_block(2, 0, 32'h3000);
        in_valid = 1'b0;
        wait_idle();
        chk("b2b_count", 32'(log_addr.size()), 32'd192);
        if (log_addr.size() == 192) begin
            chk("b2b_addr64", 32'(log_addr[64]), 32'd64);
            chk("b2b_addr191", 32'(log_addr[191]), 32'd191);
            chk("b2b_data128", log_data[128], 32'h3000);
        end
        chk("b2b_done_count", 32'(done_cyc.size()), 32'd3);
        if (done_cyc.size() == 3) begin
            chk("b2b_done_gap1", 32'(done_cyc[1] - done_cyc[0]), 32'd66);
            chk("b2b_done_gap2", 32'(done_cyc[2] - done_cyc[1]), 32'd66);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
